// File: rtl/raster_pkg.sv
// Shared types and defaults for the triangle rasterizer.
package raster_pkg;

  localparam int EW           = 24;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  typedef logic [9:0]           coord_t;
  typedef logic signed [EW-1:0] edge_t;

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  // Zero-extend an unsigned pixel coordinate into the signed edge domain.
  function automatic edge_t to_edge(input coord_t c);
    return edge_t'({{(EW-10){1'b0}}, c});
  endfunction

endpackage

// File: rtl/edge_eval.sv
// One incremental edge function E(x,y) = (xb-xa)(y-ya) - (yb-ya)(x-xa).
// Loaded at the scan origin on init, then stepped along x or to the next row.
// When neg is set the edge and its steps are negated so that the interior is
// non-negative for either winding.
module edge_eval
  import raster_pkg::*;
(
  input  logic   Clk,
  input  logic   Reset_n,
  input  logic   init,
  input  logic   step_x,
  input  logic   step_row,
  input  logic   hold,
  input  logic   neg,
  input  coord_t ax,
  input  coord_t ay,
  input  coord_t bx,
  input  coord_t by,
  input  coord_t px,
  input  coord_t py,
  output edge_t  e
);

  edge_t dx, dy, e_start;
  edge_t e_row, inc_x, inc_row;

  // Edge value at the scan origin, sign-corrected for winding.
  always_comb begin
    dx      = to_edge(bx) - to_edge(ax);
    dy      = to_edge(by) - to_edge(ay);
    e_start = dx * (to_edge(py) - to_edge(ay)) - dy * (to_edge(px) - to_edge(ax));
    if (neg) e_start = -e_start;
  end

  // Step constants, running value and row-start value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      e       <= '0;
      e_row   <= '0;
      inc_x   <= '0;
      inc_row <= '0;
    end else if (init) begin
      e       <= e_start;
      e_row   <= e_start;
      inc_x   <= neg ? dy : -dy;
      inc_row <= neg ? -dx : dx;
    end else if (!hold) begin
      if (step_row) begin
        e     <= e_row + inc_row;
        e_row <= e_row + inc_row;
      end else if (step_x) begin
        e <= e + inc_x;
      end
    end
  end

endmodule

// File: rtl/triangle_rasterizer.sv
// Scan-line triangle rasterizer: bbox scan, one pixel per cycle, covered
// pixels emitted on a valid/ready fragment stream.
// Optional build macro BACKFACE_CULL_EN: when defined, clockwise (negative
// area) triangles are discarded like degenerate ones.
//
// state | meaning
// IDLE  | waiting for a triangle, tri_ready high (after reset settles)
// SETUP | bbox, area and edge origins computed from latched vertices
// SCAN  | walking the bbox; held while the fragment output is stalled
// DONE  | scan finished; tri_done pulses on the way back to IDLE
module triangle_rasterizer
  import raster_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 tri_valid,
  output logic                 tri_ready,
  input  logic [2:0][1:0][9:0] tri_vtx,
  output logic                 frag_valid,
  input  logic                 frag_ready,
  output logic [9:0]           frag_x,
  output logic [9:0]           frag_y,
  output logic                 tri_done
);

  localparam coord_t XLIM = coord_t'(SCREEN_W - 1);
  localparam coord_t YLIM = coord_t'(SCREEN_H - 1);

  state_t state, state_nxt;
  logic [2:0][1:0][9:0] vtx_q;
  coord_t x0, y0, x1, y1, x2, y2;
  coord_t bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  coord_t xmin_q, xmax_q, ymax_q, x_q, y_q;
  edge_t  area, e01, e12, e20;
  logic   neg, cull, empty, last_q, armed;
  logic   stall, eval, row_end, covered, init, step_x, step_row;

  assign x0 = vtx_q[0][0];
  assign y0 = vtx_q[0][1];
  assign x1 = vtx_q[1][0];
  assign y1 = vtx_q[1][1];
  assign x2 = vtx_q[2][0];
  assign y2 = vtx_q[2][1];

`ifdef BACKFACE_CULL_EN
  assign cull = area[EW-1];
`else
  assign cull = 1'b0;
`endif

  // Clamped bounding box, signed area and the empty-triangle decision.
  always_comb begin
    bb_xmin = (x0 < x1) ? x0 : x1;
    if (x2 < bb_xmin) bb_xmin = x2;
    bb_ymin = (y0 < y1) ? y0 : y1;
    if (y2 < bb_ymin) bb_ymin = y2;
    bb_xmax = (x0 > x1) ? x0 : x1;
    if (x2 > bb_xmax) bb_xmax = x2;
    if (bb_xmax > XLIM) bb_xmax = XLIM;
    bb_ymax = (y0 > y1) ? y0 : y1;
    if (y2 > bb_ymax) bb_ymax = y2;
    if (bb_ymax > YLIM) bb_ymax = YLIM;
    area  = (to_edge(x1) - to_edge(x0)) * (to_edge(y2) - to_edge(y0))
          - (to_edge(y1) - to_edge(y0)) * (to_edge(x2) - to_edge(x0));
    neg   = area[EW-1];
    empty = (area == '0) || cull || (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (tri_valid && tri_ready) state_nxt = SETUP;
      SETUP: state_nxt = empty ? DONE : SCAN;
      SCAN:  if (last_q && !stall) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and scan-control outputs.
  always_comb begin
    tri_ready = armed && (state == IDLE) && !tri_done;
    stall     = frag_valid && !frag_ready;
    row_end   = (x_q == xmax_q);
    eval      = (state == SCAN) && !stall && !last_q;
    init      = (state == SETUP);
    step_x    = eval && !row_end;
    step_row  = eval && row_end && (y_q != ymax_q);
    covered   = !e01[EW-1] && !e12[EW-1] && !e20[EW-1];
  end

  // Vertex latch, scan counters, fragment register and done pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vtx_q      <= '0;
      xmin_q     <= '0;
      xmax_q     <= '0;
      ymax_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      last_q     <= 1'b0;
      frag_valid <= 1'b0;
      frag_x     <= '0;
      frag_y     <= '0;
      tri_done   <= 1'b0;
      armed      <= 1'b0;
    end else begin
      armed    <= 1'b1;
      tri_done <= (state == DONE);
      if (tri_valid && tri_ready) vtx_q <= tri_vtx;
      if (state == SETUP) begin
        xmin_q <= bb_xmin;
        xmax_q <= bb_xmax;
        ymax_q <= bb_ymax;
        x_q    <= bb_xmin;
        y_q    <= bb_ymin;
        last_q <= 1'b0;
      end else if (eval) begin
        frag_valid <= covered;
        if (covered) begin
          frag_x <= x_q;
          frag_y <= y_q;
        end
        if (row_end) begin
          x_q <= xmin_q;
          if (y_q == ymax_q) last_q <= 1'b1;
          else               y_q    <= y_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end else if (frag_valid && frag_ready) begin
        frag_valid <= 1'b0;
      end
    end
  end

  edge_eval u_e01 (
    .Clk(Clk), .Reset_n(Reset_n), .init(init), .step_x(step_x), .step_row(step_row),
    .hold(stall), .neg(neg), .ax(x0), .ay(y0), .bx(x1), .by(y1),
    .px(bb_xmin), .py(bb_ymin), .e(e01)
  );

  edge_eval u_e12 (
    .Clk(Clk), .Reset_n(Reset_n), .init(init), .step_x(step_x), .step_row(step_row),
    .hold(stall), .neg(neg), .ax(x1), .ay(y1), .bx(x2), .by(y2),
    .px(bb_xmin), .py(bb_ymin), .e(e12)
  );

  edge_eval u_e20 (
    .Clk(Clk), .Reset_n(Reset_n), .init(init), .step_x(step_x), .step_row(step_row),
    .hold(stall), .neg(neg), .ax(x2), .ay(y2), .bx(x0), .by(y0),
    .px(bb_xmin), .py(bb_ymin), .e(e20)
  );

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Scoreboard bench for triangle_rasterizer: a direct-evaluation coverage model
// fills the expected-fragment queue, a negedge monitor pops and compares.
module tb_triangle_rasterizer;

  logic                 Clk = 1'b0;
  logic                 Reset_n = 1'b0;
  logic                 tri_valid = 1'b0;
  logic                 frag_ready = 1'b1;
  logic [2:0][1:0][9:0] tri_vtx = '0;
  logic                 tri_ready, frag_valid, tri_done;
  logic [9:0]           frag_x, frag_y;

  triangle_rasterizer dut (
    .Clk(Clk), .Reset_n(Reset_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_vtx(tri_vtx), .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .tri_done(tri_done)
  );

  always #5 Clk = ~Clk;

  int total = 0, bad = 0, cyc = 0;
  logic [19:0] exp_q[$];
  int pending_done = 0, done_cnt = 0, done_cyc = 0, frag_cnt = 0;
  int first_frag_cyc = -1, acc_cyc = 0, last_exp = 0, ready_mode = 0;
  bit rdy_at_done = 1'b0, stall_prev = 1'b0, chk_bounds = 1'b0, saw_corner = 1'b0;
  logic [9:0] prev_x = '0, prev_y = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: evaluate every pixel of the clamped bbox against the three edges.
  task automatic model(input int ax, ay, bx, by, cx, cy, output int n);
    int area, s, x_lo, x_hi, y_lo, y_hi, ea, eb, ec;
    n = 0;
    area = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
    if (area == 0) return;
`ifdef BACKFACE_CULL_EN
    if (area < 0) return;
`endif
    s = (area < 0) ? -1 : 1;
    x_lo = ax; if (bx < x_lo) x_lo = bx; if (cx < x_lo) x_lo = cx;
    y_lo = ay; if (by < y_lo) y_lo = by; if (cy < y_lo) y_lo = cy;
    x_hi = ax; if (bx > x_hi) x_hi = bx; if (cx > x_hi) x_hi = cx;
    y_hi = ay; if (by > y_hi) y_hi = by; if (cy > y_hi) y_hi = cy;
    if (x_hi > 639) x_hi = 639;
    if (y_hi > 479) y_hi = 479;
    for (int y = y_lo; y <= y_hi; y++)
      for (int x = x_lo; x <= x_hi; x++) begin
        ea = s * ((bx - ax) * (y - ay) - (by - ay) * (x - ax));
        eb = s * ((cx - bx) * (y - by) - (cy - by) * (x - bx));
        ec = s * ((ax - cx) * (y - cy) - (ay - cy) * (x - cx));
        if (ea >= 0 && eb >= 0 && ec >= 0) begin
          exp_q.push_back({10'(x), 10'(y)});
          n++;
        end
      end
  endtask

  // Monitor: scoreboard pops, stall stability, done bookkeeping.
  always @(negedge Clk) begin
    logic [19:0] e;
    if (!Reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_held", int'(frag_valid), 1);
        chk("stall_x_held", int'(frag_x), int'(prev_x));
        chk("stall_y_held", int'(frag_y), int'(prev_y));
      end
      if (frag_valid) begin
        if (first_frag_cyc < 0) first_frag_cyc = cyc;
        if (frag_ready) begin
          frag_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_frag_x", int'(frag_x), -1);
          end else begin
            e = exp_q.pop_front();
            chk("frag_x", int'(frag_x), int'(e[19:10]));
            chk("frag_y", int'(frag_y), int'(e[9:0]));
          end
          if (chk_bounds) begin
            chk("x_on_screen", int'(frag_x <= 10'd639), 1);
            chk("y_on_screen", int'(frag_y <= 10'd479), 1);
          end
          if (frag_x == 10'd639 && frag_y == 10'd479) saw_corner = 1'b1;
        end
        stall_prev = !frag_ready;
        prev_x = frag_x;
        prev_y = frag_y;
      end else begin
        stall_prev = 1'b0;
      end
      if (tri_done) begin
        done_cnt++;
        done_cyc = cyc;
        rdy_at_done = tri_ready;
        chk("done_expected", int'(pending_done > 0), 1);
        if (pending_done > 0) pending_done--;
        chk("queue_empty_at_done", exp_q.size(), 0);
        chk("frag_count_at_done", frag_cnt, last_exp);
      end
    end
  end

  // frag_ready driver: 0 always ready, 1 five-cycle stall per fragment, 2 random.
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    forever begin
      @(posedge Clk);
      #1;
      case (ready_mode)
        0: begin frag_ready = 1'b1; hold_cnt = 0; end
        1: begin
          if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) frag_ready = 1'b1;
          end else if (frag_valid) begin
            frag_ready = 1'b0;
            hold_cnt = 5;
          end
        end
        default: frag_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic issue(input int ax, ay, bx, by, cx, cy);
    int n, w;
    model(ax, ay, bx, by, cx, cy, n);
    pending_done++;
    @(posedge Clk);
    #1;
    tri_vtx[0][0] = 10'(ax); tri_vtx[0][1] = 10'(ay);
    tri_vtx[1][0] = 10'(bx); tri_vtx[1][1] = 10'(by);
    tri_vtx[2][0] = 10'(cx); tri_vtx[2][1] = 10'(cy);
    tri_valid = 1'b1;
    w = 0;
    do begin
      @(negedge Clk);
      w++;
    end while (!tri_ready && w < 100);
    chk("accept_before_timeout", int'(tri_ready), 1);
    @(posedge Clk);
    #1;
    acc_cyc = cyc;
    tri_valid = 1'b0;
    frag_cnt = 0;
    first_frag_cyc = -1;
    last_exp = n;
  endtask

  task automatic wait_done(input int budget, output int lat);
    int start, w;
    start = done_cnt;
    w = 0;
    while (done_cnt == start && w < budget) begin
      @(posedge Clk);
      w++;
    end
    chk("done_before_timeout", int'(done_cnt != start), 1);
    lat = done_cyc - acc_cyc;
    chk("ready_low_with_done", int'(rdy_at_done), 0);
    @(negedge Clk);
    #1;
    chk("ready_after_done", int'(tri_ready), 1);
  endtask

  initial begin
    int lat, w, d0;
    int ax, ay, bx, by, cx, cy, ox, oy;

    #12;
    chk("reset_tri_ready", int'(tri_ready), 0);
    chk("reset_frag_valid", int'(frag_valid), 0);
    chk("reset_frag_x", int'(frag_x), 0);
    chk("reset_frag_y", int'(frag_y), 0);
    chk("reset_tri_done", int'(tri_done), 0);
    #10 Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    chk("ready_after_reset", int'(tri_ready), 1);

    // Right triangle: 66 fragments, first at (10,10) two cycles after accept.
    issue(10, 10, 20, 10, 10, 20);
    wait_done(2000, lat);
    chk("t1_count", frag_cnt, 66);
    chk("t1_first_frag_latency", first_frag_cyc - acc_cyc, 2);

    // Reversed winding.
    issue(10, 10, 10, 20, 20, 10);
    wait_done(2000, lat);
`ifdef BACKFACE_CULL_EN
    chk("t2_count", frag_cnt, 0);
    chk("t2_done_latency", lat, 2);
`else
    chk("t2_count", frag_cnt, 66);
`endif

    // Collinear.
    issue(0, 0, 5, 5, 10, 10);
    wait_done(100, lat);
    chk("t3_count", frag_cnt, 0);
    chk("t3_done_latency", lat, 2);

    // Screen-edge clamping.
    chk_bounds = 1'b1;
    saw_corner = 1'b0;
    issue(600, 470, 1000, 470, 600, 1000);
    wait_done(2000, lat);
    chk("t4_corner_fragment", int'(saw_corner), 1);
    chk_bounds = 1'b0;

    // Back-pressure on every fragment.
    ready_mode = 1;
    issue(10, 10, 20, 10, 10, 20);
    wait_done(5000, lat);
    chk("t5_count", frag_cnt, 66);
    ready_mode = 0;
    repeat (2) @(posedge Clk);

    // Reset in the middle of a scan.
    issue(10, 10, 20, 10, 10, 20);
    w = 0;
    while (frag_cnt < 20 && w < 500) begin
      @(posedge Clk);
      w++;
    end
    chk("t6_reached_mid_scan", int'(frag_cnt >= 20), 1);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("t6_frag_valid_async", int'(frag_valid), 0);
    chk("t6_ready_in_reset", int'(tri_ready), 0);
    exp_q.delete();
    pending_done = 0;
    d0 = done_cnt;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    repeat (4) @(posedge Clk);
    chk("t6_no_done", done_cnt, d0);
    @(negedge Clk);
    chk("t6_ready_after_release", int'(tri_ready), 1);
    issue(10, 10, 20, 10, 10, 20);
    wait_done(2000, lat);
    chk("t6_count_after_reset", frag_cnt, 66);

    // Entirely off-screen bbox.
    issue(700, 10, 800, 10, 700, 50);
    wait_done(100, lat);
    chk("offscreen_count", frag_cnt, 0);
    chk("offscreen_done_latency", lat, 2);

    // Random triangles, random back-pressure, some straddling the screen edge.
    ready_mode = 2;
    for (int t = 0; t < 10; t++) begin
      ox = ($urandom_range(0, 1) != 0) ? 600 : 0;
      oy = ($urandom_range(0, 1) != 0) ? 440 : 0;
      ax = ox + $urandom_range(0, 45); ay = oy + $urandom_range(0, 45);
      bx = ox + $urandom_range(0, 45); by = oy + $urandom_range(0, 45);
      cx = ox + $urandom_range(0, 45); cy = oy + $urandom_range(0, 45);
      issue(ax, ay, bx, by, cx, cy);
      wait_done(12000, lat);
    end
    ready_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
